// File: rtl/iob_axis2ahb_burst_split.sv
// Splits a read/write command into AHB-legal chunks (<= MAX_BURST words, never crossing
// BOUNDARY) and feeds them one at a time to the iob_axis2ahb config handshakes.
module iob_axis2ahb_burst_split #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16,
    parameter int BOUNDARY   = 1024
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  done_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic                  s_axis_tlast_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tlast_o,
    output logic [ADDR_WIDTH-1:0] config_in_addr_o,
    output logic                  config_in_valid_o,
    input  logic                  config_in_ready_i,
    output logic [ADDR_WIDTH-1:0] config_out_addr_o,
    output logic [ADDR_WIDTH-1:0] config_out_length_o,
    output logic                  config_out_valid_o,
    input  logic                  config_out_ready_i
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int CW    = $clog2(MAX_BURST + 1);
    localparam int WW    = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BND_MASK   = ADDR_WIDTH'(BOUNDARY - 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DATA} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  write;
    logic [CW-1:0]         chunk;
    logic [CW-1:0]         beat_cnt;

    logic [WW-1:0]         room;
    logic [WW-1:0]         fit;
    logic [CW-1:0]         chunk_calc;
    logic                  in_data;
    logic                  beat;
    logic                  advance;
    logic                  unused_tlast;

    assign unused_tlast = s_axis_tlast_i;

    // Words left before the boundary, then clamp by MAX_BURST and remaining length.
    always_comb begin
        room = WW'(BOUNDARY / BYTES) - WW'((addr & BND_MASK) >> OFFS);
        fit  = WW'(MAX_BURST);
        if (WW'(remaining) < fit) fit = WW'(remaining);
        if (room < fit) fit = room;
        chunk_calc = CW'(fit);
    end

    assign in_data         = (state == DATA);
    assign beat            = in_data && s_axis_tvalid_i && m_axis_tready_i;
    assign advance         = (state == ISSUE && !write && config_out_ready_i)
                             || (beat && beat_cnt == CW'(1));
    assign cmd_ready_o     = (state == IDLE);
    assign m_axis_tdata_o  = s_axis_tdata_i;
    assign m_axis_tvalid_o = in_data && s_axis_tvalid_i;
    assign s_axis_tready_o = in_data && m_axis_tready_i;
    assign m_axis_tlast_o  = in_data && (beat_cnt == CW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= IDLE;
            addr                <= '0;
            remaining           <= '0;
            write               <= 1'b0;
            chunk               <= '0;
            beat_cnt            <= '0;
            done_o              <= 1'b0;
            config_in_valid_o   <= 1'b0;
            config_in_addr_o    <= '0;
            config_out_valid_o  <= 1'b0;
            config_out_addr_o   <= '0;
            config_out_length_o <= '0;
        end else if (cke_i) begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr      <= cmd_addr_i & ALIGN_MASK;
                        remaining <= cmd_len_i;
                        write     <= cmd_write_i;
                        if (cmd_len_i == '0) done_o <= 1'b1;
                        else                 state  <= CALC;
                    end
                end
                CALC: begin
                    chunk <= chunk_calc;
                    if (write) begin
                        config_in_valid_o <= 1'b1;
                        config_in_addr_o  <= addr;
                    end else begin
                        config_out_valid_o  <= 1'b1;
                        config_out_addr_o   <= addr;
                        config_out_length_o <= ADDR_WIDTH'(chunk_calc) - ADDR_WIDTH'(1);
                    end
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (write) begin
                        if (config_in_ready_i) begin
                            config_in_valid_o <= 1'b0;
                            beat_cnt          <= chunk;
                            state             <= DATA;
                        end
                    end else if (config_out_ready_i) begin
                        config_out_valid_o <= 1'b0;
                    end
                end
                DATA: begin
                    if (beat) beat_cnt <= beat_cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase

            // Shared chunk completion for read handshakes and the final write beat.
            if (advance) begin
                addr      <= addr + (ADDR_WIDTH'(chunk) << OFFS);
                remaining <= remaining - LEN_WIDTH'(chunk);
                if (remaining == LEN_WIDTH'(chunk)) begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                end else begin
                    state <= CALC;
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_axis2ahb_burst_split.sv
// Self-checking bench for iob_axis2ahb_burst_split: directed scenarios plus randomized
// commands, checked cycle by cycle against a chunk-list reference model.
module tb_iob_axis2ahb_burst_split;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 16;
    localparam int MB  = 16;
    localparam int BND = 1024;
    localparam int BY  = DW / 8;

    localparam int P_CMD   = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DATA  = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          cke, rst;
    logic          cmd_valid, cmd_ready, cmd_write, done;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] s_tdata, m_tdata;
    logic          s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
    logic [AW-1:0] cin_addr, cout_addr, cout_len;
    logic          cin_valid, cin_ready, cout_valid, cout_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] a;
        int unsigned   c;
    } chunk_t;

    chunk_t        q[$];
    logic [DW-1:0] wdata[$];

    iob_axis2ahb_burst_split #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .MAX_BURST (MB),
        .BOUNDARY  (BND)
    ) dut (
        .clk_i              (clk),
        .cke_i              (cke),
        .rst_i              (rst),
        .cmd_valid_i        (cmd_valid),
        .cmd_ready_o        (cmd_ready),
        .cmd_write_i        (cmd_write),
        .cmd_addr_i         (cmd_addr),
        .cmd_len_i          (cmd_len),
        .done_o             (done),
        .s_axis_tdata_i     (s_tdata),
        .s_axis_tvalid_i    (s_tvalid),
        .s_axis_tready_o    (s_tready),
        .s_axis_tlast_i     (s_tlast),
        .m_axis_tdata_o     (m_tdata),
        .m_axis_tvalid_o    (m_tvalid),
        .m_axis_tready_i    (m_tready),
        .m_axis_tlast_o     (m_tlast),
        .config_in_addr_o   (cin_addr),
        .config_in_valid_o  (cin_valid),
        .config_in_ready_i  (cin_ready),
        .config_out_addr_o  (cout_addr),
        .config_out_length_o(cout_len),
        .config_out_valid_o (cout_valid),
        .config_out_ready_i (cout_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the list of (address, words) chunks a command must become.
    task automatic plan(input logic [AW-1:0] addr, input int unsigned len);
        logic [AW-1:0] a;
        int unsigned   r, c, room;
        q.delete();
        a = addr & ~AW'(BY - 1);
        r = len;
        while (r > 0) begin
            c    = (r < MB) ? r : MB;
            room = (BND - int'(a % BND)) / BY;
            if (room < c) c = room;
            q.push_back('{a: a, c: c});
            a = a + AW'(c * BY);
            r = r - c;
        end
    endtask

    // rmode: 0 random readies, 1 always ready, 2 config ready held low 5 valid cycles.
    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input int unsigned len,
                           input int rmode, input bit cke_rand,
                           output int nchunks, output int nbeats);
        int          phase, gap, fin, stall;
        int unsigned left, idx;
        bit          en, finished, rdy;
        logic        expv;
        plan(addr, len);
        wdata.delete();
        for (int unsigned i = 0; i < len; i++) wdata.push_back($urandom);
        phase = P_CMD; gap = 0; fin = 0; stall = 0; left = 0; idx = 0;
        nchunks = 0; nbeats = 0; finished = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            en  = cke_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            cke = en;
            if (phase == P_CMD) begin
                cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = LW'(len);
            end else begin
                cmd_valid = (phase != P_DONE) && ($urandom_range(0, 1) == 1);
                cmd_write = 1'($urandom);
                cmd_addr  = $urandom;
                cmd_len   = LW'($urandom_range(0, 5));
            end
            if (rmode == 1) begin
                cin_ready = 1'b1; cout_ready = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
            end else begin
                cin_ready  = (rmode == 2) ? (stall >= 5) : ($urandom_range(0, 1) == 1);
                cout_ready = (rmode == 2) ? (stall >= 5) : ($urandom_range(0, 1) == 1);
                s_tvalid   = ($urandom_range(0, 2) != 0);
                m_tready   = ($urandom_range(0, 1) == 1);
            end
            s_tdata = (idx < len) ? wdata[idx] : $urandom;
            s_tlast = 1'($urandom);
            rdy     = wr ? cin_ready : cout_ready;
            #1;
            if (phase != P_DONE) check("done_early", 64'(done), 64'(0));
            case (phase)
                P_CMD: begin
                    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
                    check("cfg_valid_idle", 64'({cin_valid, cout_valid}), 64'(0));
                    check("axis_idle", 64'({s_tready, m_tvalid, m_tlast}), 64'(0));
                    if (en) begin
                        if (len == 0) begin phase = P_DONE; fin = 0; end
                        else begin phase = P_ISSUE; gap = 0; end
                    end
                end
                P_ISSUE: begin
                    expv = (gap >= 2);
                    check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
                    check("axis_issue", 64'({s_tready, m_tvalid, m_tlast}), 64'(0));
                    check("cin_valid", 64'(cin_valid), 64'(wr & expv));
                    check("cout_valid", 64'(cout_valid), 64'(!wr & expv));
                    if (expv) begin
                        if (wr) check("cin_addr", 64'(cin_addr), 64'(q[0].a));
                        else begin
                            check("cout_addr", 64'(cout_addr), 64'(q[0].a));
                            check("cout_len", 64'(cout_len), 64'(q[0].c - 1));
                        end
                        if (en && rdy) begin
                            nchunks++;
                            stall = 0;
                            if (wr) begin
                                phase = P_DATA; left = q[0].c;
                            end else begin
                                void'(q.pop_front());
                                if (q.size() == 0) begin phase = P_DONE; fin = 0; end
                                else gap = 0;
                            end
                        end else if (en) stall++;
                    end
                end
                P_DATA: begin
                    check("cmd_ready_data", 64'(cmd_ready), 64'(0));
                    check("cfg_valid_data", 64'({cin_valid, cout_valid}), 64'(0));
                    check("m_tvalid", 64'(m_tvalid), 64'(s_tvalid));
                    check("s_tready", 64'(s_tready), 64'(m_tready));
                    check("m_tlast", 64'(m_tlast), 64'(left == 1));
                    if (s_tvalid && idx < len) check("m_tdata", 64'(m_tdata), 64'(wdata[idx]));
                    if (en && s_tvalid && m_tready) begin
                        nbeats++; idx++; left--;
                        if (left == 0) begin
                            void'(q.pop_front());
                            if (q.size() == 0) begin phase = P_DONE; fin = 0; end
                            else begin phase = P_ISSUE; gap = 0; end
                        end
                    end
                end
                default: begin
                    check("cmd_ready_done", 64'(cmd_ready), 64'(1));
                    check("cfg_valid_done", 64'({cin_valid, cout_valid}), 64'(0));
                    check("done_pulse", 64'(done), 64'(fin == 1));
                    if (fin == 1 && en) finished = 1'b1;
                end
            endcase
            if (en) begin gap++; fin++; end
        end
        if (!finished) check("timeout", 64'(0), 64'(1));
        check("beat_total", 64'(nbeats), 64'(wr ? len : 0));
    endtask

    initial begin
        int          nc, nb;
        logic [AW-1:0] ra;
        cke = 1'b1; rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        cin_ready = 1'b0; cout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_valids", 64'({cin_valid, cout_valid}), 64'(0));
        check("rst_axis", 64'({s_tready, m_tvalid, m_tlast}), 64'(0));
        check("rst_cin_addr", 64'(cin_addr), 64'(0));
        check("rst_cout_addr", 64'(cout_addr), 64'(0));
        check("rst_cout_len", 64'(cout_len), 64'(0));
        rst = 1'b0;

        run_cmd(1'b0, 32'h0000_03F8, 10, 1, 1'b0, nc, nb);
        check("rd_boundary_chunks", 64'(nc), 64'(2));
        run_cmd(1'b1, 32'h0000_0000, 40, 1, 1'b0, nc, nb);
        check("wr40_chunks", 64'(nc), 64'(3));
        run_cmd(1'b1, 32'h0000_0020, 3, 0, 1'b0, nc, nb);
        check("wr3_beats", 64'(nb), 64'(3));
        run_cmd(1'b1, 32'h0000_0100, 0, 0, 1'b0, nc, nb);
        check("len0_chunks", 64'(nc), 64'(0));
        run_cmd(1'b0, 32'h0000_03C0, 20, 2, 1'b0, nc, nb);
        check("rd_stall_chunks", 64'(nc), 64'(2));

        // Reset in the middle of a 16-beat write.
        @(negedge clk);
        cke = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '0; cmd_len = 16;
        cin_ready = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !s_tready; i++) @(negedge clk);
        check("rst_mid_reach_data", 64'(s_tready), 64'(1));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_mid_valids", 64'({cin_valid, cout_valid}), 64'(0));
        check("rst_mid_axis", 64'({s_tready, m_tvalid, m_tlast}), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        s_tvalid = 1'b0; m_tready = 1'b0; cin_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_done", 64'(done), 64'(0));
        end
        run_cmd(1'b0, 32'h0000_1000, 5, 0, 1'b0, nc, nb);
        check("after_rst_read", 64'(nc), 64'(1));

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'hFFFF_FFC0 + AW'($urandom_range(0, 63));
                1:       ra = ($urandom & ~AW'(BND - 1)) - AW'($urandom_range(0, 80));
                default: ra = $urandom;
            endcase
            run_cmd(1'($urandom), ra, $urandom_range(0, 60), 0, 1'b1, nc, nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_axis2ahb_burst_split.md
# iob_axis2ahb_burst_split

Command splitter placed directly upstream of `iob_axis2ahb`.
- Accepts one transfer command (write or read, start address, length in data words).
- Breaks it into chunks that never exceed `MAX_BURST` words and never cross a `BOUNDARY`-byte address boundary, as the AHB burst rules require.
- Drives the `config_in_*` / `config_out_*` handshakes of the AHB adapter, one chunk at a time.
- For writes, forwards the AXIS stream into the adapter and regenerates `tlast` at the end of each chunk.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: AXIS/AHB data width. Word size is `DATA_WIDTH/8` bytes.
- `LEN_WIDTH`, 16: command length width, in words.
- `MAX_BURST`, 16: maximum words per chunk. Power of two, ≥1.
- `BOUNDARY`, 1024: byte boundary a chunk must not cross. Power of two, ≥ `MAX_BURST*DATA_WIDTH/8`.

Ports:
- `clk_i`  in  1  clock.
- `cke_i`  in  1  clock enable. When low, all state holds.
- `rst_i`  in  1  synchronous reset, active-high.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command ready.
- `cmd_write_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  `ADDR_WIDTH`  start byte address. Low `log2(DATA_WIDTH/8)` bits are ignored (forced to 0).
- `cmd_len_i`  in  `LEN_WIDTH`  number of words.
- `done_o`  out  1  one-cycle pulse when the command completes.
- `s_axis_tdata_i`  in  `DATA_WIDTH`  write data in.
- `s_axis_tvalid_i`  in  1  write data valid.
- `s_axis_tready_o`  out  1  write data ready.
- `s_axis_tlast_i`  in  1  ignored.
- `m_axis_tdata_o`  out  `DATA_WIDTH`  data to the adapter's `in_axis`.
- `m_axis_tvalid_o`  out  1  data valid to the adapter.
- `m_axis_tready_i`  in  1  data ready from the adapter.
- `m_axis_tlast_o`  out  1  last beat of the current chunk.
- `config_in_addr_o`  out  `ADDR_WIDTH`  write chunk address.
- `config_in_valid_o`  out  1  write chunk request valid.
- `config_in_ready_i`  in  1  write chunk request ready.
- `config_out_addr_o`  out  `ADDR_WIDTH`  read chunk address.
- `config_out_length_o`  out  `ADDR_WIDTH`  read chunk length minus one (the adapter transfers length+1 beats).
- `config_out_valid_o`  out  1  read chunk request valid.
- `config_out_ready_i`  in  1  read chunk request ready.

## Operation
Registered state: address, remaining words, write flag, chunk size, beat counter.

State machine:
- **IDLE**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`: latch the command.
  - If `cmd_len_i`==0: pulse `done_o` next cycle and stay in IDLE.
  - Otherwise go to CALC.
- **CALC**
  - `chunk = min(remaining, MAX_BURST, (BOUNDARY - addr%BOUNDARY)/(DATA_WIDTH/8))`. Chunk is 1..`MAX_BURST`.
  - Register `chunk`, then go to ISSUE.
- **ISSUE**
  - Write: assert `config_in_valid_o` with `config_in_addr_o`=addr. On ready, load beat counter = chunk and go to DATA.
  - Read: assert `config_out_valid_o` with `config_out_addr_o`=addr and `config_out_length_o`=chunk-1. On ready, apply the chunk update (below).
  - Valid holds and address/length stay stable until ready.
- **DATA** (write only)
  - Combinational pass-through: `m_axis_tvalid_o`=`s_axis_tvalid_i`, `s_axis_tready_o`=`m_axis_tready_i`, `m_axis_tdata_o`=`s_axis_tdata_i`.
  - `m_axis_tlast_o` = (beat counter == 1).
  - Each accepted beat (valid & ready) decrements the counter.
  - On the last beat, apply the chunk update.
- **Chunk update**
  - `addr += chunk*(DATA_WIDTH/8)`, modulo 2^`ADDR_WIDTH`.
  - `remaining -= chunk`.
  - If remaining==0: go to IDLE and pulse `done_o` on the next cycle. Otherwise go to CALC.

Other rules:
- Outside DATA: `s_axis_tready_o`=0, `m_axis_tvalid_o`=0, `m_axis_tlast_o`=0.
- Commands presented while not in IDLE are not accepted (ready is low).
- Read data does not pass through this block. The adapter's `out_axis` goes straight to the consumer. The adapter's config ready is the only flow control for reads.

## Timing
- Reset values:
  - `cmd_ready_o`=1 (IDLE).
  - `done_o`, both config valids, `s_axis_tready_o`, `m_axis_tvalid_o`, `m_axis_tlast_o` = 0.
  - Config address/length outputs = 0.
- Reset mid-command: returns to IDLE the next cycle and drops the command. No `done_o`. No valid stays asserted.
- Command accepted in cycle T:
  - CALC in T+1.
  - Config valid first high in T+2.
  - Each later chunk's valid rises 2 cycles after the previous chunk finishes.
- `done_o` is high for exactly one cycle, the cycle after the final config handshake (read) or the final write beat.
- Config valids, addresses and lengths are registered. The DATA-state AXIS path is combinational, with zero latency.
- `cke_i`=0 freezes all registers. Combinational pass-through still follows its inputs, but the beat counter does not advance.

## Test plan
- Read, addr 0x3F8, len 10, DATA_WIDTH 32 → two config_out requests: (0x3F8, length 1) then (0x400, length 7). `done_o` pulses once, after the second handshake.
- Write, addr 0x0, len 40, MAX_BURST 16 → config_in at 0x0, 0x40, 0x80. `m_axis_tlast_o` on beats 16, 32 and 40. Total beats exactly 40. `done_o` after beat 40.
- Write, len 3, with `m_axis_tready_i` toggling 1/0 and `s_axis_tvalid_i` gaps → data order preserved, no beat lost or duplicated, `tlast` only on beat 3.
- `cmd_len_i`=0 → no config valid ever asserted. `done_o` pulses at T+1. `cmd_ready_o` stays 1.
- `config_out_ready_i` held low for 5 cycles → valid, address and length stable throughout. One handshake when ready rises.
- `rst_i` asserted during DATA of a 16-beat write → next cycle all valids/ready low except `cmd_ready_o`=1, and `done_o` stays 0. A new read command then completes normally.
